mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL have parameter MUL_LAT, default 5, meaning busy cycles after mult/multu issue (range 1..31).
REQ-002 The block SHALL have parameter DIV_LAT, default 10, meaning busy cycles after div/divu issue (range 1..31).
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port instr  input  32  instruction-register contents, stable from DECODE onward.
REQ-006 The block SHALL have port cmp_true  input  1  branch-compare result, valid in EXEC.
REQ-007 The block SHALL have outputs pc_we(1), ir_we(1), npc_op(3), alu_op(4), ext_op(1), alu_b_sel(1), dm_we(1), dm_op(3), grf_we(1), grf_a3_sel(2), grf_wd_sel(2), with the same encodings as the single-cycle controller.
REQ-008 The block SHALL have outputs mdu_start(1), mdu_op(2), mdu_busy(1), state(3), instr_done(1) and illegal(1).

Function
REQ-009 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and MDUWAIT=5; codes 6 and 7 SHALL go to FETCH on the next edge.
REQ-010 Decoding SHALL use standard MIPS32 encodings for addu, subu, slt, ori, lui, lw, lh, lhu, lb, lbu, sw, sh, sb, beq, j, jal and jr.
REQ-011 FETCH SHALL assert ir_we=1 and pc_we=1 with npc_op=PC+4, then go to DECODE.
REQ-012 DECODE SHALL handle j/jr with pc_we=1, npc_op=j or jr, instr_done=1, then go to FETCH.
REQ-013 DECODE SHALL handle jal with pc_we=1, grf_we=1, grf_a3_sel=ra, grf_wd_sel=pc4 and instr_done=1, then go to FETCH.
REQ-014 DECODE SHALL send every other legal instruction to EXEC.
REQ-015 DECODE SHALL treat an undecodable instruction as follows: illegal=1 and instr_done=1 for one cycle, no write enables asserted, then go to FETCH.
REQ-016 EXEC for beq SHALL set pc_we=cmp_true, npc_op=branch and instr_done=1, then go to FETCH.
REQ-017 EXEC for loads and stores SHALL select alu_op=add with sign-extended immediate, then go to MEM.
REQ-018 EXEC for ALU-type instructions SHALL drive alu_op, ext_op and alu_b_sel per instruction, then go to WB.
REQ-019 MEM SHALL drive dm_op for all memory instructions.
REQ-020 MEM for stores SHALL assert dm_we=1 and instr_done=1, then go to FETCH.
REQ-021 MEM for loads SHALL go to WB.
REQ-022 WB SHALL assert grf_we=1, with grf_a3_sel=rd for R-type and rt otherwise, and grf_wd_sel=dmrd for loads and aluans otherwise.
REQ-023 WB SHALL assert instr_done=1, then go to FETCH.
REQ-024 Every output not named for the current state/instruction SHALL be 0.
REQ-025 All outputs SHALL be combinational from the state register and instr (Moore in state, decoded by instr); there SHALL be no registered outputs besides state.
REQ-026 Per-instruction latency SHALL be: j/jr/jal 2 cycles, beq 3, ALU 4, store 4, load 5 (FETCH to final state inclusive).
REQ-027 instr_done SHALL be exactly one cycle per instruction.
REQ-028 dm_we and grf_we SHALL never both be 1 in the same cycle.

Reset
REQ-029 While reset=1, state SHALL be FETCH and the MDU counter SHALL be 0, immediately and asynchronously.
REQ-030 During reset, all outputs other than state SHALL be forced to 0, including FETCH's ir_we and pc_we.
REQ-031 On reset deassertion, FETCH SHALL begin on the first rising edge.
REQ-032 Reset mid-instruction SHALL abandon the instruction with no further writes.

Configuration
REQ-033 Macro MC_CTRL_MDU_EN, when defined, SHALL add decoding of mult, multu, div, divu, mfhi, mflo, mthi and mtlo.
REQ-034 With MC_CTRL_MDU_EN, EXEC for mult/multu/div/divu SHALL pulse mdu_start=1 with mdu_op=0/1/2/3, load the 5-bit counter with MUL_LAT or DIV_LAT, assert instr_done=1, then go to FETCH.
REQ-035 With MC_CTRL_MDU_EN, the counter SHALL decrement each cycle while nonzero, and mdu_busy SHALL equal (counter!=0).
REQ-036 With MC_CTRL_MDU_EN, mfhi/mflo/mthi/mtlo/mult/div reaching EXEC while mdu_busy=1 SHALL go to MDUWAIT and hold there, all enables 0, until the counter reaches 0, then re-enter EXEC.
REQ-037 With MC_CTRL_MDU_EN, mfhi/mflo SHALL then go to WB writing rd with grf_wd_sel=3 (hi/lo).
REQ-038 With MC_CTRL_MDU_EN, mthi/mtlo SHALL pulse mdu_start with mdu_op=0/1 plus a one-cycle-latency flag (no counter load), finish, and go to FETCH.
REQ-039 With MC_CTRL_MDU_EN, a non-MDU instruction SHALL proceed normally while mdu_busy=1.
REQ-040 Without MC_CTRL_MDU_EN, MDU instructions SHALL decode as illegal, mdu_start, mdu_op and mdu_busy SHALL be tied 0, and MDUWAIT SHALL be unreachable.

Verification
REQ-041 The bench SHALL release reset and run addu $3,$1,$2: states 0,1,2,4 visible; grf_we=1 only in cycle 4 with a3_sel=rd; instr_done pulses once.
REQ-042 The bench SHALL run lw then sw: lw asserts grf_we with wd_sel=dmrd in cycle 5; sw asserts dm_we=1 only in cycle 4; no grf_we during sw.
REQ-043 The bench SHALL run beq with cmp_true=0, then with cmp_true=1: pc_we in EXEC equals 0, then 1, with npc_op=branch; jal writes ra in DECODE, 2 cycles total.
REQ-044 The bench SHALL feed instr=0xFC000000: illegal=1 and instr_done=1 in DECODE; all write enables 0; next state FETCH.
REQ-045 With MC_CTRL_MDU_EN, MUL_LAT=5, the bench SHALL run mult immediately followed by mflo: mdu_start once; mflo sits in MDUWAIT until mdu_busy falls; grf_we with wd_sel=3 follows.
REQ-046 The bench SHALL assert reset in MEM of sw: dm_we drops to 0 asynchronously, state=0, and FETCH resumes one edge after release.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS controller: FETCH/DECODE/EXEC/MEM/WB sequencing with combinational outputs.
// Define MC_CTRL_MDU_EN to add mult/div/mfhi/mflo/mthi/mtlo with a busy counter and MDUWAIT stall.
module mc_ctrl #(
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic        cmp_true,
   output logic        pc_we,
   output logic        ir_we,
   output logic [2:0]  npc_op,
   output logic [3:0]  alu_op,
   output logic        ext_op,
   output logic        alu_b_sel,
   output logic        dm_we,
   output logic [2:0]  dm_op,
   output logic        grf_we,
   output logic [1:0]  grf_a3_sel,
   output logic [1:0]  grf_wd_sel,
   output logic        mdu_start,
   output logic [1:0]  mdu_op,
   output logic        mdu_mt,
   output logic        mdu_busy,
   output logic [2:0]  state,
   output logic        instr_done,
   output logic        illegal
);

   localparam logic [2:0] NPC_PC4 = 3'd0, NPC_BR = 3'd1, NPC_J = 3'd2, NPC_JR = 3'd3;
   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_OR = 4'd2, ALU_SLT = 4'd3, ALU_LUI = 4'd4;
   localparam logic [2:0] DM_W = 3'd0, DM_H = 3'd1, DM_HU = 3'd2, DM_B = 3'd3, DM_BU = 3'd4;
   localparam logic [1:0] A3_RT = 2'd0, A3_RD = 2'd1, A3_RA = 2'd2;
   localparam logic [1:0] WD_ALU = 2'd0, WD_DMRD = 2'd1, WD_PC4 = 2'd2, WD_HILO = 2'd3;

   typedef enum logic [2:0] {
      S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_MDUWAIT = 3'd5
   } state_t;

   typedef enum logic [3:0] {
      C_ILL, C_J, C_JR, C_JAL, C_BEQ, C_LOAD, C_STORE, C_ALU_R, C_ALU_I,
      C_MDU_CALC, C_MDU_MF, C_MDU_MT
   } cls_t;

   state_t      state_reg, state_next;
   cls_t        cls;
   logic [3:0]  dec_alu;
   logic        dec_ext;
   logic [2:0]  dec_dm;
   logic [1:0]  dec_mdu_op;
   logic        mdu_load;
   logic [4:0]  mdu_lat;
   logic        busy_int;

   wire [5:0] opcode = instr[31:26];
   wire [5:0] funct  = instr[5:0];

   logic unused_fields;
   assign unused_fields = ^instr[25:6];

   always_comb begin
      cls        = C_ILL;
      dec_alu    = ALU_ADD;
      dec_ext    = 1'b0;
      dec_dm     = DM_W;
      dec_mdu_op = 2'd0;
      case (opcode)
         6'h00: begin
            case (funct)
               6'h21: cls = C_ALU_R;
               6'h23: begin cls = C_ALU_R; dec_alu = ALU_SUB; end
               6'h2a: begin cls = C_ALU_R; dec_alu = ALU_SLT; end
               6'h08: cls = C_JR;
`ifdef MC_CTRL_MDU_EN
               6'h18, 6'h19, 6'h1a, 6'h1b: begin cls = C_MDU_CALC; dec_mdu_op = funct[1:0]; end
               6'h10, 6'h12: cls = C_MDU_MF;
               6'h11, 6'h13: begin cls = C_MDU_MT; dec_mdu_op = {1'b0, funct[1]}; end
`endif
               default: cls = C_ILL;
            endcase
         end
         6'h0d: begin cls = C_ALU_I; dec_alu = ALU_OR; end
         6'h0f: begin cls = C_ALU_I; dec_alu = ALU_LUI; end
         6'h23: begin cls = C_LOAD;  dec_dm = DM_W;  end
         6'h21: begin cls = C_LOAD;  dec_dm = DM_H;  end
         6'h25: begin cls = C_LOAD;  dec_dm = DM_HU; end
         6'h20: begin cls = C_LOAD;  dec_dm = DM_B;  end
         6'h24: begin cls = C_LOAD;  dec_dm = DM_BU; end
         6'h2b: begin cls = C_STORE; dec_dm = DM_W;  end
         6'h29: begin cls = C_STORE; dec_dm = DM_H;  end
         6'h28: begin cls = C_STORE; dec_dm = DM_B;  end
         6'h04: cls = C_BEQ;
         6'h02: cls = C_J;
         6'h03: cls = C_JAL;
         default: cls = C_ILL;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= S_FETCH;
      else       state_reg <= state_next;
   end

`ifdef MC_CTRL_MDU_EN
   logic [4:0] mdu_cnt_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                  mdu_cnt_reg <= 5'd0;
      else if (mdu_load)          mdu_cnt_reg <= mdu_lat;
      else if (mdu_cnt_reg != 0)  mdu_cnt_reg <= mdu_cnt_reg - 5'd1;
   end

   assign busy_int = (mdu_cnt_reg != 5'd0);
`else
   logic unused_mdu;
   assign unused_mdu = mdu_load ^ (^mdu_lat);
   assign busy_int   = 1'b0;
`endif

   always_comb begin
      state_next = S_FETCH;
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      npc_op     = NPC_PC4;
      alu_op     = ALU_ADD;
      ext_op     = 1'b0;
      alu_b_sel  = 1'b0;
      dm_we      = 1'b0;
      dm_op      = DM_W;
      grf_we     = 1'b0;
      grf_a3_sel = A3_RT;
      grf_wd_sel = WD_ALU;
      mdu_start  = 1'b0;
      mdu_op     = 2'd0;
      mdu_mt     = 1'b0;
      mdu_busy   = busy_int;
      instr_done = 1'b0;
      illegal    = 1'b0;
      mdu_load   = 1'b0;
      mdu_lat    = 5'd0;
      case (state_reg)
         S_FETCH: begin
            ir_we      = 1'b1;
            pc_we      = 1'b1;
            state_next = S_DECODE;
         end
         S_DECODE: begin
            case (cls)
               C_J:   begin pc_we = 1'b1; npc_op = NPC_J;  instr_done = 1'b1; end
               C_JR:  begin pc_we = 1'b1; npc_op = NPC_JR; instr_done = 1'b1; end
               C_JAL: begin
                  pc_we      = 1'b1;
                  npc_op     = NPC_J;
                  grf_we     = 1'b1;
                  grf_a3_sel = A3_RA;
                  grf_wd_sel = WD_PC4;
                  instr_done = 1'b1;
               end
               C_ILL: begin illegal = 1'b1; instr_done = 1'b1; end
               default: state_next = S_EXEC;
            endcase
         end
         S_EXEC: begin
            case (cls)
               C_BEQ: begin pc_we = cmp_true; npc_op = NPC_BR; instr_done = 1'b1; end
               C_LOAD, C_STORE: begin
                  alu_op = ALU_ADD; ext_op = 1'b1; alu_b_sel = 1'b1; state_next = S_MEM;
               end
               C_ALU_R: begin alu_op = dec_alu; state_next = S_WB; end
               C_ALU_I: begin
                  alu_op = dec_alu; ext_op = dec_ext; alu_b_sel = 1'b1; state_next = S_WB;
               end
               // Any HI/LO access while a mult/div is in flight must stall.
               C_MDU_CALC: begin
                  if (busy_int) state_next = S_MDUWAIT;
                  else begin
                     mdu_start  = 1'b1;
                     mdu_op     = dec_mdu_op;
                     mdu_load   = 1'b1;
                     mdu_lat    = dec_mdu_op[1] ? 5'(DIV_LAT) : 5'(MUL_LAT);
                     instr_done = 1'b1;
                  end
               end
               C_MDU_MF: state_next = busy_int ? S_MDUWAIT : S_WB;
               C_MDU_MT: begin
                  if (busy_int) state_next = S_MDUWAIT;
                  else begin
                     mdu_start  = 1'b1;
                     mdu_op     = dec_mdu_op;
                     mdu_mt     = 1'b1;
                     instr_done = 1'b1;
                  end
               end
               default: state_next = S_FETCH;
            endcase
         end
         S_MEM: begin
            dm_op = dec_dm;
            if (cls == C_STORE) begin
               dm_we      = 1'b1;
               instr_done = 1'b1;
            end else if (cls == C_LOAD) begin
               state_next = S_WB;
            end
         end
         S_WB: begin
            grf_we     = 1'b1;
            grf_a3_sel = (cls == C_ALU_R || cls == C_MDU_MF) ? A3_RD : A3_RT;
            grf_wd_sel = (cls == C_LOAD) ? WD_DMRD : (cls == C_MDU_MF) ? WD_HILO : WD_ALU;
            instr_done = 1'b1;
         end
         S_MDUWAIT: begin
`ifdef MC_CTRL_MDU_EN
            state_next = busy_int ? S_MDUWAIT : S_EXEC;
`else
            state_next = S_FETCH;
`endif
         end
         default: state_next = S_FETCH;
      endcase
      // Reset masks every control output, including FETCH's own enables.
      if (reset) begin
         pc_we      = 1'b0;
         ir_we      = 1'b0;
         npc_op     = 3'd0;
         alu_op     = 4'd0;
         ext_op     = 1'b0;
         alu_b_sel  = 1'b0;
         dm_we      = 1'b0;
         dm_op      = 3'd0;
         grf_we     = 1'b0;
         grf_a3_sel = 2'd0;
         grf_wd_sel = 2'd0;
         mdu_start  = 1'b0;
         mdu_op     = 2'd0;
         mdu_mt     = 1'b0;
         mdu_busy   = 1'b0;
         instr_done = 1'b0;
         illegal    = 1'b0;
      end
   end

   assign state = state_reg;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks instructions cycle by cycle and checks state plus every output.
module tb_mc_ctrl;
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr;
   logic        cmp_true;
   logic        pc_we, ir_we, ext_op, alu_b_sel, dm_we, grf_we;
   logic        mdu_start, mdu_mt, mdu_busy, instr_done, illegal;
   logic [2:0]  npc_op, dm_op, state;
   logic [3:0]  alu_op;
   logic [1:0]  grf_a3_sel, grf_wd_sel, mdu_op;

   int total = 0;
   int bad   = 0;

   localparam logic [2:0] NPC_PC4 = 3'd0, NPC_BR = 3'd1, NPC_J = 3'd2;
   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [2:0] DM_W = 3'd0;
   localparam logic [1:0] A3_RT = 2'd0, A3_RD = 2'd1, A3_RA = 2'd2;
   localparam logic [1:0] WD_ALU = 2'd0, WD_DMRD = 2'd1, WD_PC4 = 2'd2, WD_HILO = 2'd3;

   mc_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (
      .clk(clk), .reset(reset), .instr(instr), .cmp_true(cmp_true),
      .pc_we(pc_we), .ir_we(ir_we), .npc_op(npc_op), .alu_op(alu_op), .ext_op(ext_op),
      .alu_b_sel(alu_b_sel), .dm_we(dm_we), .dm_op(dm_op), .grf_we(grf_we),
      .grf_a3_sel(grf_a3_sel), .grf_wd_sel(grf_wd_sel), .mdu_start(mdu_start),
      .mdu_op(mdu_op), .mdu_mt(mdu_mt), .mdu_busy(mdu_busy), .state(state),
      .instr_done(instr_done), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // Field order: pc_we ir_we npc alu ext bsel dm_we dm_op grf_we a3 wd done illegal
   function automatic logic [21:0] o(input logic pcw, input logic irw, input logic [2:0] npc,
                                     input logic [3:0] alu, input logic ext, input logic bsel,
                                     input logic dmwe, input logic [2:0] dmop, input logic grfwe,
                                     input logic [1:0] a3, input logic [1:0] wd,
                                     input logic done, input logic ill);
      return {pcw, irw, npc, alu, ext, bsel, dmwe, dmop, grfwe, a3, wd, done, ill};
   endfunction

   logic [21:0] obs_vec;
   logic [4:0]  obs_mdu;
   assign obs_vec = {pc_we, ir_we, npc_op, alu_op, ext_op, alu_b_sel, dm_we, dm_op,
                     grf_we, grf_a3_sel, grf_wd_sel, instr_done, illegal};
   assign obs_mdu = {mdu_start, mdu_op, mdu_mt, mdu_busy};

   logic [21:0] f_out, zero_out, ldst_exec;
   initial begin
      f_out     = o(1, 1, NPC_PC4, ALU_ADD, 0, 0, 0, DM_W, 0, A3_RT, WD_ALU, 0, 0);
      zero_out  = 22'd0;
      ldst_exec = o(0, 0, NPC_PC4, ALU_ADD, 1, 1, 0, DM_W, 0, A3_RT, WD_ALU, 0, 0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // mdu field order: start op[1:0] mt busy
   task automatic cyc(input string tag, input logic [2:0] st, input logic [21:0] ev,
                      input logic [4:0] em);
      total++;
      assert (state === st) else begin
         bad++;
         $error("FAIL %s state: got %0d want %0d", tag, state, st);
      end
      total++;
      assert ({obs_vec, obs_mdu} === {ev, em}) else begin
         bad++;
         $error("FAIL %s outputs: got %h/%b want %h/%b", tag, obs_vec, obs_mdu, ev, em);
      end
      $display("step %s: state=%0d outs=%h mdu=%b", tag, state, obs_vec, obs_mdu);
   endtask

   initial begin
      reset    = 1'b1;
      instr    = 32'h0022_1821;
      cmp_true = 1'b0;
      #12;
      cyc("reset hold", 3'd0, zero_out, 5'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;

      // addu $3,$1,$2
      cyc("addu fetch", 3'd0, f_out, 5'd0);    tick();
      cyc("addu decode", 3'd1, zero_out, 5'd0); tick();
      cyc("addu exec", 3'd2, zero_out, 5'd0);   tick();
      cyc("addu wb", 3'd4, o(0,0,NPC_PC4,ALU_ADD,0,0,0,DM_W,1,A3_RD,WD_ALU,1,0), 5'd0); tick();

      // lw $4,8($1)
      instr = 32'h8C24_0008;
      cyc("lw fetch", 3'd0, f_out, 5'd0);       tick();
      cyc("lw decode", 3'd1, zero_out, 5'd0);   tick();
      cyc("lw exec", 3'd2, ldst_exec, 5'd0);    tick();
      cyc("lw mem", 3'd3, zero_out, 5'd0);      tick();
      cyc("lw wb", 3'd4, o(0,0,NPC_PC4,ALU_ADD,0,0,0,DM_W,1,A3_RT,WD_DMRD,1,0), 5'd0); tick();

      // sw $4,12($1)
      instr = 32'hAC24_000C;
      cyc("sw fetch", 3'd0, f_out, 5'd0);       tick();
      cyc("sw decode", 3'd1, zero_out, 5'd0);   tick();
      cyc("sw exec", 3'd2, ldst_exec, 5'd0);    tick();
      cyc("sw mem", 3'd3, o(0,0,NPC_PC4,ALU_ADD,0,0,1,DM_W,0,A3_RT,WD_ALU,1,0), 5'd0); tick();

      // beq not taken, then taken
      instr = 32'h1022_0004;
      cmp_true = 1'b0;
      cyc("beq0 fetch", 3'd0, f_out, 5'd0);     tick();
      cyc("beq0 decode", 3'd1, zero_out, 5'd0); tick();
      cyc("beq0 exec", 3'd2, o(0,0,NPC_BR,ALU_ADD,0,0,0,DM_W,0,A3_RT,WD_ALU,1,0), 5'd0); tick();
      cmp_true = 1'b1;
      cyc("beq1 fetch", 3'd0, f_out, 5'd0);     tick();
      cyc("beq1 decode", 3'd1, zero_out, 5'd0); tick();
      cyc("beq1 exec", 3'd2, o(1,0,NPC_BR,ALU_ADD,0,0,0,DM_W,0,A3_RT,WD_ALU,1,0), 5'd0); tick();
      cmp_true = 1'b0;

      // jal 0x100
      instr = 32'h0C00_0100;
      cyc("jal fetch", 3'd0, f_out, 5'd0);      tick();
      cyc("jal decode", 3'd1, o(1,0,NPC_J,ALU_ADD,0,0,0,DM_W,1,A3_RA,WD_PC4,1,0), 5'd0); tick();

      // undecodable opcode
      instr = 32'hFC00_0000;
      cyc("ill fetch", 3'd0, f_out, 5'd0);      tick();
      cyc("ill decode", 3'd1, o(0,0,NPC_PC4,ALU_ADD,0,0,0,DM_W,0,A3_RT,WD_ALU,1,1), 5'd0); tick();

`ifdef MC_CTRL_MDU_EN
      // mult $1,$2 then mflo $5 stalling on the busy counter
      instr = 32'h0022_0018;
      cyc("mult fetch", 3'd0, f_out, 5'd0);     tick();
      cyc("mult decode", 3'd1, zero_out, 5'd0); tick();
      cyc("mult exec", 3'd2, o(0,0,NPC_PC4,ALU_ADD,0,0,0,DM_W,0,A3_RT,WD_ALU,1,0), 5'b10000); tick();
      instr = 32'h0000_2812;
      cyc("mflo fetch", 3'd0, f_out, 5'b00001); tick();
      cyc("mflo decode", 3'd1, zero_out, 5'b00001); tick();
      cyc("mflo exec busy", 3'd2, zero_out, 5'b00001); tick();
      cyc("mflo wait1", 3'd5, zero_out, 5'b00001); tick();
      cyc("mflo wait2", 3'd5, zero_out, 5'b00001); tick();
      cyc("mflo wait3", 3'd5, zero_out, 5'd0);  tick();
      cyc("mflo exec", 3'd2, zero_out, 5'd0);   tick();
      cyc("mflo wb", 3'd4, o(0,0,NPC_PC4,ALU_ADD,0,0,0,DM_W,1,A3_RD,WD_HILO,1,0), 5'd0); tick();
`else
      // mult is not decodable without the MDU option
      instr = 32'h0022_0018;
      cyc("mult fetch", 3'd0, f_out, 5'd0);     tick();
      cyc("mult ill", 3'd1, o(0,0,NPC_PC4,ALU_ADD,0,0,0,DM_W,0,A3_RT,WD_ALU,1,1), 5'd0); tick();
`endif

      // reset asserted during sw MEM
      instr = 32'hAC24_000C;
      cyc("rsw fetch", 3'd0, f_out, 5'd0);      tick();
      cyc("rsw decode", 3'd1, zero_out, 5'd0);  tick();
      cyc("rsw exec", 3'd2, ldst_exec, 5'd0);   tick();
      cyc("rsw mem", 3'd3, o(0,0,NPC_PC4,ALU_ADD,0,0,1,DM_W,0,A3_RT,WD_ALU,1,0), 5'd0);
      #2;
      reset = 1'b1;
      #1;
      cyc("rsw async", 3'd0, zero_out, 5'd0);
      tick();
      cyc("rsw held", 3'd0, zero_out, 5'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      cyc("rsw release", 3'd0, f_out, 5'd0);    tick();
      cyc("rsw resume", 3'd1, zero_out, 5'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not finish, got running want done");
      $fatal(1, "timeout");
   end

endmodule
